uart_tx_fifo: RTL

//  UART transmitter with configurable frame format and an input FIFO.
//  The frame format (data bits, parity, stop bits) is set by parameters.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with parameterised frame format and an input FIFO.
// Frames are sent back-to-back, LSB first, from a valid/ready-fed queue.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT  = 217,
   parameter int NUM_DATA_BITS = 8,
   parameter int PARITY_MODE   = 0,
   parameter int NUM_STOP_BITS = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_txValid,
   input  logic [NUM_DATA_BITS-1:0]       i_txByte,
   output logic                           o_txReady,
   output logic                           o_tx,
   output logic                           o_txActive,
   output logic                           o_txDoneStrobe,
   output logic                           o_overflowStrobe,
   output logic [$clog2(FIFO_DEPTH):0]    o_fifoCount
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
   localparam logic ODD = (PARITY_MODE == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                   state_q, state_d;
   logic [BW-1:0]            cnt_q, cnt_d;
   logic [3:0]               idx_q, idx_d;
   logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
   logic                     par_q, par_d;
   logic                     tx_q, tx_d;
   logic                     active_q, active_d;
   logic                     done_q, done_d;
   logic                     ovf_q;
   logic [NUM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]            wr_q, rd_q;
   logic [CW-1:0]            count_q;
   logic                     push, pop, bit_end, not_empty;
   logic [NUM_DATA_BITS-1:0] head;

   assign o_txReady        = count_q != CW'(FIFO_DEPTH);
   assign push             = i_txValid && o_txReady;
   assign not_empty        = count_q != '0;
   assign head             = mem_q[rd_q];
   assign bit_end          = cnt_q == BW'(CLKS_PER_BIT - 1);
   assign o_tx             = tx_q;
   assign o_txActive       = active_q;
   assign o_txDoneStrobe   = done_q;
   assign o_overflowStrobe = ovf_q;
   assign o_fifoCount      = count_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = (state_q == IDLE || bit_end) ? '0 : cnt_q + BW'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tx_d     = tx_q;
      active_d = active_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      case (state_q)
         IDLE:
            if (not_empty) begin
               pop      = 1'b1;
               state_d  = START;
               tx_d     = 1'b0;
               active_d = 1'b1;
               shift_d  = head;
               par_d    = (^head) ^ ODD;
            end
         START:
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               idx_d   = '0;
            end
         DATA:
            if (bit_end) begin
               if (idx_q == 4'(NUM_DATA_BITS - 1)) begin
                  state_d = HAS_PAR ? PARITY : STOP;
                  tx_d    = HAS_PAR ? par_q : 1'b1;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  tx_d    = shift_q[1];
                  shift_d = shift_q >> 1;
               end
            end
         PARITY:
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
               idx_d   = '0;
            end
         STOP:
            if (bit_end) begin
               if (idx_q == 4'(NUM_STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  // chain straight into the next frame when work is queued
                  if (not_empty) begin
                     pop     = 1'b1;
                     state_d = START;
                     tx_d    = 1'b0;
                     shift_d = head;
                     par_d   = (^head) ^ ODD;
                  end else begin
                     state_d  = IDLE;
                     tx_d     = 1'b1;
                     active_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         default: begin
            state_d  = IDLE;
            tx_d     = 1'b1;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
         ovf_q    <= i_txValid && !o_txReady;
         wr_q     <= push ? wr_q + AW'(1) : wr_q;
         rd_q     <= pop ? rd_q + AW'(1) : rd_q;
         count_q  <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_q] <= i_txByte;
   end
endmodule
